// File: rtl/spi_slave_responder.sv
// SPI responder shift engine: oversamples SCLK/SS_N/MOSI, shifts one DATA_W frame per select.
// Optional macro SPI_RESP_LSB_FIRST_EN switches both shift directions to LSB-first.
module spi_slave_responder #(
  parameter int DATA_W      = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              SCLK,
  input  logic              SS_N,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_WRITE,
  output logic              TX_FULL,
  output logic [DATA_W-1:0] RX_DATA,
  input  logic              RX_READ,
  output logic              RX_FULL,
  output logic              OVERRUN,
  output logic              UNDERRUN,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

`ifdef SPI_RESP_LSB_FIRST_EN
  function automatic logic tx_head(input logic [DATA_W-1:0] v);
    return v[0];
  endfunction
  function automatic logic [DATA_W-1:0] tx_next(input logic [DATA_W-1:0] v);
    return {1'b0, v[DATA_W-1:1]};
  endfunction
  function automatic logic [DATA_W-1:0] rx_next(input logic [DATA_W-1:0] v, input logic b);
    return {b, v[DATA_W-1:1]};
  endfunction
`else
  function automatic logic tx_head(input logic [DATA_W-1:0] v);
    return v[DATA_W-1];
  endfunction
  function automatic logic [DATA_W-1:0] tx_next(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], 1'b0};
  endfunction
  function automatic logic [DATA_W-1:0] rx_next(input logic [DATA_W-1:0] v, input logic b);
    return {v[DATA_W-2:0], b};
  endfunction
`endif

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;

  // Synchronizers and one-cycle history for edge detection
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      ss_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sclk_prev_q <= CPOL;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_N};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ss_s, mosi_s, lead_s, trail_s, sample_s, shift_s, ss_fall_s;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign lead_s    = (sclk_s != CPOL) && (sclk_prev_q == CPOL);
  assign trail_s   = (sclk_s == CPOL) && (sclk_prev_q != CPOL);
  assign sample_s  = CPHA ? trail_s : lead_s;
  assign shift_s   = CPHA ? lead_s : trail_s;
  assign ss_fall_s = !ss_s && ss_prev_q;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]  tx_buf_q, tx_buf_d, rx_data_q, rx_data_d;
  logic               tx_full_q, tx_full_d, rx_full_q, rx_full_d;
  logic               ovr_q, ovr_d, und_q, und_d;
  logic               miso_q, miso_d, miso_oe_q, miso_oe_d, busy_q, busy_d;
  logic               tx_consume_s, und_set_s, done_s;

  // Next-state, shift datapath and holding-buffer logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    rx_data_d    = rx_data_q;
    miso_d       = miso_q;
    tx_consume_s = 1'b0;
    und_set_s    = 1'b0;
    done_s       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall_s) state_d = ST_LOAD;
        else           state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (tx_full_q) begin
          tx_sr_d      = tx_buf_q;
          tx_consume_s = 1'b1;
        end else begin
          tx_sr_d   = '0;
          und_set_s = 1'b1;
        end
        miso_d  = tx_head(tx_sr_d);
        rx_sr_d = '0;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ss_s) begin
          state_d = ST_IDLE;
        end else if (sample_s) begin
          rx_sr_d = rx_next(rx_sr_q, mosi_s);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_DONE;
          else                             state_d = ST_SHIFT;
        end else if (shift_s && (cnt_q != '0)) begin
          // A shift edge before the first sample keeps the head bit on the line
          tx_sr_d = tx_next(tx_sr_q);
          miso_d  = tx_head(tx_sr_d);
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        rx_data_d = rx_sr_q;
        done_s    = 1'b1;
        cnt_d     = '0;
        if (ss_s) state_d = ST_IDLE;
        else      state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tx_buf_d  = tx_buf_q;
    tx_full_d = tx_consume_s ? 1'b0 : tx_full_q;
    if (TX_WRITE && (!tx_full_q || tx_consume_s)) begin
      tx_buf_d  = TX_DATA;
      tx_full_d = 1'b1;
    end else begin
      tx_buf_d  = tx_buf_q;
    end

    if (und_set_s)     und_d = 1'b1;
    else if (TX_WRITE) und_d = 1'b0;
    else               und_d = und_q;

    if (done_s) begin
      rx_full_d = 1'b1;
      if (RX_READ)        ovr_d = 1'b0;
      else if (rx_full_q) ovr_d = 1'b1;
      else                ovr_d = ovr_q;
    end else if (RX_READ) begin
      rx_full_d = 1'b0;
      ovr_d     = 1'b0;
    end else begin
      rx_full_d = rx_full_q;
      ovr_d     = ovr_q;
    end

    busy_d    = (state_d != ST_IDLE);
    miso_oe_d = (state_d != ST_IDLE) && !ss_s;
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      tx_buf_q  <= '0;
      rx_data_q <= '0;
      tx_full_q <= 1'b0;
      rx_full_q <= 1'b0;
      ovr_q     <= 1'b0;
      und_q     <= 1'b0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      tx_buf_q  <= tx_buf_d;
      rx_data_q <= rx_data_d;
      tx_full_q <= tx_full_d;
      rx_full_q <= rx_full_d;
      ovr_q     <= ovr_d;
      und_q     <= und_d;
      miso_q    <= miso_d;
      miso_oe_q <= miso_oe_d;
      busy_q    <= busy_d;
    end
  end

  assign MISO     = miso_q;
  assign MISO_OE  = miso_oe_q;
  assign TX_FULL  = tx_full_q;
  assign RX_DATA  = rx_data_q;
  assign RX_FULL  = rx_full_q;
  assign OVERRUN  = ovr_q;
  assign UNDERRUN = und_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a mode-0 and a mode-3 instance driven by a bit-level SPI master,
// checked against a frame-level model of the holding buffers and sticky flags.
module tb_spi_slave_responder;
  localparam int W = 8;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clr;
  logic [1:0]   sclk, ss_n, mosi, txw, rxr;
  logic [W-1:0] txd [2];
  wire  [1:0]   miso, oe, txf, rxf, ovr, und, busy;
  wire  [W-1:0] rxd0, rxd1;

  spi_slave_responder #(.DATA_W(W), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(SYNC)) dut0 (
    .CLK(clk), .CLR(clr), .SCLK(sclk[0]), .SS_N(ss_n[0]), .MOSI(mosi[0]),
    .MISO(miso[0]), .MISO_OE(oe[0]), .TX_DATA(txd[0]), .TX_WRITE(txw[0]), .TX_FULL(txf[0]),
    .RX_DATA(rxd0), .RX_READ(rxr[0]), .RX_FULL(rxf[0]), .OVERRUN(ovr[0]),
    .UNDERRUN(und[0]), .BUSY(busy[0]));

  spi_slave_responder #(.DATA_W(W), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(SYNC)) dut1 (
    .CLK(clk), .CLR(clr), .SCLK(sclk[1]), .SS_N(ss_n[1]), .MOSI(mosi[1]),
    .MISO(miso[1]), .MISO_OE(oe[1]), .TX_DATA(txd[1]), .TX_WRITE(txw[1]), .TX_FULL(txf[1]),
    .RX_DATA(rxd1), .RX_READ(rxr[1]), .RX_FULL(rxf[1]), .OVERRUN(ovr[1]),
    .UNDERRUN(und[1]), .BUSY(busy[1]));

  int n_chk = 0;
  int n_fail = 0;

  // Frame-level reference state per instance
  logic         m_txf [2], m_rxf [2], m_ovr [2], m_und [2];
  logic [W-1:0] m_txb [2], m_rxd [2], m_cur [2];

  function automatic logic [W-1:0] rxd_of(input int s);
    return (s == 0) ? rxd0 : rxd1;
  endfunction

  // Position on the wire of the i-th transmitted bit
  function automatic int bidx(input int i);
`ifdef SPI_RESP_LSB_FIRST_EN
    return i;
`else
    return W - 1 - i;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_txf[s] = 1'b0; m_rxf[s] = 1'b0; m_ovr[s] = 1'b0; m_und[s] = 1'b0;
      m_txb[s] = '0;   m_rxd[s] = '0;   m_cur[s] = '0;
    end
  endtask

  task automatic model_load(input int s);
    if (m_txf[s]) begin
      m_cur[s] = m_txb[s];
      m_txf[s] = 1'b0;
    end else begin
      m_cur[s] = '0;
      m_und[s] = 1'b1;
    end
  endtask

  task automatic model_done(input int s, input logic [W-1:0] d, input bit rd);
    if (rd) m_ovr[s] = 1'b0;
    else if (m_rxf[s]) m_ovr[s] = 1'b1;
    m_rxd[s] = d;
    m_rxf[s] = 1'b1;
  endtask

  task automatic check_reset(input int s, input string tag);
    chk({tag, "_miso"}, miso[s], 1'b0);
    chk({tag, "_oe"},   oe[s],   1'b0);
    chk({tag, "_txf"},  txf[s],  1'b0);
    chk({tag, "_rxf"},  rxf[s],  1'b0);
    chk({tag, "_rxd"},  rxd_of(s), '0);
    chk({tag, "_ovr"},  ovr[s],  1'b0);
    chk({tag, "_und"},  und[s],  1'b0);
    chk({tag, "_busy"}, busy[s], 1'b0);
  endtask

  task automatic check_flags(input int s, input string tag);
    chk({tag, "_rxd"}, rxd_of(s), m_rxd[s]);
    chk({tag, "_rxf"}, rxf[s], m_rxf[s]);
    chk({tag, "_ovr"}, ovr[s], m_ovr[s]);
    chk({tag, "_und"}, und[s], m_und[s]);
    chk({tag, "_txf"}, txf[s], m_txf[s]);
  endtask

  task automatic tx_write(input int s, input logic [W-1:0] d);
    txd[s] = d; txw[s] = 1'b1;
    cyc(1);
    txw[s] = 1'b0;
    if (!m_txf[s]) begin
      m_txb[s] = d;
      m_txf[s] = 1'b1;
    end
    m_und[s] = 1'b0;
  endtask

  task automatic rx_read(input int s);
    rxr[s] = 1'b1;
    cyc(1);
    rxr[s] = 1'b0;
    m_rxf[s] = 1'b0;
    m_ovr[s] = 1'b0;
  endtask

  // Master clocks nbits out; rd pulses RX_READ in the cycle the last sample completes the frame
  task automatic frame(input int s, input logic [W-1:0] md, input int nbits, input bit rd,
                       output logic [W-1:0] got);
    int b;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      b = bidx(i);
      if (s == 1) sclk[1] = 1'b0;
      mosi[s] = md[b];
      cyc(5);
      got[b] = miso[s];
      sclk[s] = (s == 0) ? 1'b1 : 1'b1;
      if (rd && (i == nbits - 1)) begin
        cyc(SYNC + 1);
        rxr[s] = 1'b1;
        cyc(1);
        rxr[s] = 1'b0;
        cyc(1);
      end else begin
        cyc(5);
      end
      if (s == 0) sclk[0] = 1'b0;
    end
  endtask

  task automatic session(input int s, input int n, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input int abort_bits, input bit rd2, input string tag);
    logic [W-1:0] got, d, exp_tx;
    ss_n[s] = 1'b0;
    cyc(12);
    model_load(s);
    for (int f = 0; f < n; f++) begin
      d = (f == 0) ? d0 : d1;
      exp_tx = m_cur[s];
      frame(s, d, W, rd2 && (f == 1), got);
      model_done(s, d, rd2 && (f == 1));
      model_load(s);
      cyc(2);
      chk({tag, "_miso_bits"}, got, exp_tx);
      check_flags(s, tag);
      chk({tag, "_busy"}, busy[s], 1'b1);
      chk({tag, "_oe"}, oe[s], 1'b1);
    end
    if (abort_bits > 0) frame(s, W'($urandom), abort_bits, 1'b0, got);
    cyc(2);
    ss_n[s] = 1'b1;
    cyc(SYNC + 2);
    chk({tag, "_end_busy"}, busy[s], 1'b0);
    chk({tag, "_end_oe"}, oe[s], 1'b0);
    chk({tag, "_end_rxf"}, rxf[s], m_rxf[s]);
    cyc(4);
  endtask

  initial begin
    logic [W-1:0] got;
    clr = 1'b0;
    sclk = 2'b10; ss_n = 2'b11; mosi = 2'b00; txw = 2'b00; rxr = 2'b00;
    txd[0] = '0; txd[1] = '0;
    model_reset();
    cyc(3);
    check_reset(0, "rst0");
    check_reset(1, "rst1");
    clr = 1'b1;
    cyc(2);

    tx_write(0, 8'hA5);
    chk("t1_txf_after_write", txf[0], 1'b1);
    session(0, 1, 8'h3C, 8'h00, 0, 1'b0, "t1");

    rx_read(0);
    session(0, 1, 8'hFF, 8'h00, 0, 1'b0, "t2");

    rx_read(0);
    session(0, 2, 8'h11, 8'h22, 0, 1'b0, "t3a");
    rx_read(0);
    chk("t3_read_rxf", rxf[0], 1'b0);
    chk("t3_read_ovr", ovr[0], 1'b0);
    session(0, 2, 8'h11, 8'h22, 0, 1'b1, "t3b");

    rx_read(0);
    tx_write(0, W'($urandom));
    session(0, 0, 8'h00, 8'h00, 5, 1'b0, "t4");

    tx_write(1, 8'h81);
    session(1, 1, 8'h7E, 8'h00, 0, 1'b0, "t5");

    for (int k = 0; k < 3; k++) begin
      rx_read(0);
      if ($urandom_range(1) == 1) tx_write(0, W'($urandom));
      session(0, 1 + int'($urandom_range(1)), W'($urandom), W'($urandom), 0, 1'b0, "rnd0");
    end
    tx_write(1, W'($urandom));
    session(1, 2, W'($urandom), W'($urandom), 0, 1'b0, "rnd1");

    tx_write(0, 8'h5A);
    ss_n[0] = 1'b0;
    cyc(12);
    model_load(0);
    tx_write(0, 8'hC3);
    chk("t6_txf_midframe", txf[0], 1'b1);
    frame(0, 8'h96, 3, 1'b0, got);
    clr = 1'b0;
    ss_n[0] = 1'b1;
    cyc(1);
    check_reset(0, "t6rst0");
    check_reset(1, "t6rst1");
    clr = 1'b1;
    model_reset();
    cyc(4);
    session(0, 1, W'($urandom), 8'h00, 0, 1'b0, "t6post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
SPI responder (slave) shift engine: the serial end opposite the master-side sender/receiver control.
- Oversamples external SCLK/SS_N/MOSI in the CLK domain.
- Shifts one DATA_W-bit frame per SS_N assertion.
- Drives MISO from a single-entry TX holding buffer and delivers received frames to a single-entry RX holding buffer.
- Parallel side connects to the wishbone control/status logic.

Parameters:
DATA_W, 8, frame width in bits (2..32)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge
SYNC_STAGES, 2, synchronizer flops on SCLK/SS_N/MOSI (2..3)

Ports:
CLK  input  1  system clock; all logic on rising edge
CLR  input  1  synchronous reset, active-low (CLR==0 resets on the next CLK rising edge)
SCLK  input  1  SPI clock from master (asynchronous)
SS_N  input  1  slave select, active-low (asynchronous)
MOSI  input  1  master-out data (asynchronous)
MISO  output  1  slave-out data
MISO_OE  output  1  MISO drive enable; 1 only while SS_N (synchronized) is low
TX_DATA  input  DATA_W  frame to send
TX_WRITE  input  1  one-cycle strobe; loads TX_DATA into TX holding buffer
TX_FULL  output  1  TX holding buffer occupied
RX_DATA  output  DATA_W  last received frame
RX_READ  input  1  one-cycle strobe; frees RX holding buffer
RX_FULL  output  1  RX holding buffer occupied
OVERRUN  output  1  sticky: frame completed while RX_FULL=1
UNDERRUN  output  1  sticky: frame started with TX_FULL=0
BUSY  output  1  frame in progress

Behaviour:
- Reset values: MISO=0, MISO_OE=0, TX_FULL=0, RX_FULL=0, RX_DATA=0, OVERRUN=0, UNDERRUN=0, BUSY=0; FSM=IDLE; bit counter=0; synchronizers are preset to SCLK=CPOL, SS_N=1.
- Reset mid-frame aborts the frame. Nothing is written to RX, and the TX buffer is cleared.
- Edge detection uses the synchronized SCLK. Leading edge is the transition away from CPOL; trailing edge is the return to CPOL. Input-to-detect latency is SYNC_STAGES+1 CLK cycles. The master's SCLK half-period must be at least 4 CLK cycles.
- FSM states:
  - IDLE: MISO_OE=0. On synchronized SS_N falling, go to LOAD.
  - LOAD (1 cycle):
    - If TX_FULL=1: shift register <= TX buffer and TX_FULL <= 0.
    - Otherwise: shift register <= all-zeros and UNDERRUN <= 1.
    - MISO_OE <= 1, MISO <= MSB of the shift register. BUSY <= 1. Go to SHIFT.
  - SHIFT:
    - Sample edge: capture MOSI into the RX shift register LSB (shift left) and increment bit count.
    - Shift edge: present the next TX bit on MISO.
    - CPHA=1 only: the first leading edge presents the MSB and no shift occurs before it.
    - When bit count reaches DATA_W after a sample edge, go to DONE.
  - DONE (1 cycle):
    - RX_DATA <= RX shift register and RX_FULL <= 1.
    - If RX_FULL was already 1: OVERRUN <= 1 and RX_DATA is still overwritten with the new frame.
    - Bit count <= 0. If SS_N is still low, go to LOAD (back-to-back frame); otherwise go to IDLE.
- SS_N rising during SHIFT (aborted frame): discard partial RX, do not set RX_FULL, go to IDLE. BUSY=0, MISO_OE=0 on the next cycle.
- SS_N rising in IDLE/DONE: go to IDLE normally.
- TX_WRITE:
  - When TX_FULL=0: loads the buffer and TX_FULL=1 on the next cycle.
  - When TX_FULL=1: ignored (data is not overwritten).
  - In the same cycle as LOAD consumes the buffer: the write is accepted, so TX_FULL stays 1 holding the new data.
- RX_READ:
  - Clears RX_FULL on the next cycle.
  - Coincident with DONE: DONE wins, RX_FULL stays 1 with the new data, and OVERRUN is not set.
- OVERRUN/UNDERRUN clear only by reset or by RX_READ/TX_WRITE respectively.
- BUSY is 1 from LOAD through DONE inclusive.
- MISO holds its last value when MISO_OE=0; the external pad tri-states.

Optional Feature:
SPI_RESP_LSB_FIRST_EN.
- Defined: both TX and RX shift LSB-first. MISO presents bit 0 first, and received bits enter at the MSB and shift right. RX_DATA is therefore bit-order-correct.
- Undefined: MSB-first as described in Behaviour.

Test Plan:
1. Mode 0, DATA_W=8, SCLK period 10 CLK. TX_WRITE 0xA5, then master sends 0x3C. Required: MISO bit sequence 1,0,1,0,0,1,0,1; RX_DATA=0x3C; RX_FULL=1 two cycles after the 8th sample edge; TX_FULL=0 after LOAD.
2. No TX_WRITE before SS_N falls, master sends 0xFF. Required: MISO all 0, UNDERRUN=1, RX_DATA=0xFF.
3. Two back-to-back frames 0x11 then 0x22 with no RX_READ. Required: OVERRUN=1 and RX_DATA=0x22. RX_READ coincident with the 2nd DONE instead: OVERRUN stays 0.
4. SS_N deasserted after 5 sample edges. Required: RX_FULL stays 0, BUSY=0 within SYNC_STAGES+2 cycles, MISO_OE=0.
5. CPOL=1, CPHA=1, TX 0x81, master sends 0x7E. Required: MISO 1,0,0,0,0,0,0,1 aligned to leading edges; RX_DATA=0x7E.
6. CLR=0 asserted mid-frame with TX_FULL=1. Required: all outputs return to reset values on the next CLK edge; TX_FULL=0. The following full frame completes normally with UNDERRUN=1.
